// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the 2R/1W 32x32 register file: ALU writes take priority,
// memory loads queue in a small FIFO, and read-port hazards are reported to decode.
module rf_wr_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        rf_clock,
  input  logic        rf_reset,
  input  logic        alu_wr_valid,
  input  logic [4:0]  alu_wr_addr,
  input  logic [31:0] alu_wr_data,
  input  logic        mem_wr_valid,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  output logic        mem_wr_ready,
  input  logic [4:0]  rd_addr_0,
  input  logic [4:0]  rd_addr_1,
  output logic        rd_pending_0,
  output logic        rd_pending_1,
  output logic        rf_wr_enable,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [2:0]  fifo_count
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic             push_live;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign mem_wr_ready = !rf_reset && (fifo_count < DEPTH_C);
  assign push         = mem_wr_valid && mem_wr_ready;
  assign pop          = !alu_wr_valid && (fifo_count != 3'd0);
  // A load pushed alongside an ALU write to the same register is already stale.
  assign push_live    = !(alu_wr_valid && (alu_wr_addr == mem_wr_addr));

  always_ff @(posedge rf_clock) begin
    if (rf_reset) begin
      head         <= '0;
      tail         <= '0;
      fifo_count   <= 3'd0;
      ent_valid    <= '0;
      ent_live     <= '1;
      rf_wr_enable <= 1'b0;
      rf_wr_addr   <= 5'd0;
      rf_wr_data   <= 32'd0;
    end else begin
      // The ALU write supersedes every buffered load to the same register.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_wr_valid && ent_valid[PW'(i)] && (ent_addr[PW'(i)] == alu_wr_addr))
          ent_live[PW'(i)] <= 1'b0;
      end

      if (push) begin
        ent_addr[tail]  <= mem_wr_addr;
        ent_data[tail]  <= mem_wr_data;
        ent_valid[tail] <= 1'b1;
        ent_live[tail]  <= push_live;
        tail            <= inc_ptr(tail);
      end

      if (alu_wr_valid) begin
        rf_wr_enable <= 1'b1;
        rf_wr_addr   <= alu_wr_addr;
        rf_wr_data   <= alu_wr_data;
      end else if (pop) begin
        rf_wr_enable    <= ent_live[head];
        if (ent_live[head]) begin
          rf_wr_addr <= ent_addr[head];
          rf_wr_data <= ent_data[head];
        end
        ent_valid[head] <= 1'b0;
        head            <= inc_ptr(head);
      end else begin
        rf_wr_enable <= 1'b0;
      end

      fifo_count <= fifo_count + 3'(push) - 3'(pop);
    end
  end

  // Hazard: register is in the output stage or queued as a live load.
  always_comb begin
    rd_pending_0 = rf_wr_enable && (rf_wr_addr == rd_addr_0);
    rd_pending_1 = rf_wr_enable && (rf_wr_addr == rd_addr_1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[PW'(i)] && ent_live[PW'(i)]) begin
        if (ent_addr[PW'(i)] == rd_addr_0) rd_pending_0 = 1'b1;
        if (ent_addr[PW'(i)] == rd_addr_1) rd_pending_1 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the write port.
module tb_rf_wr_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rf_reset;
  logic        alu_wr_valid;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        mem_wr_valid;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic [4:0]  rd_addr_0;
  logic [4:0]  rd_addr_1;
  logic        rd_pending_0;
  logic        rd_pending_1;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DEPTH(DEPTH)) dut (
    .rf_clock     (clk),
    .rf_reset     (rf_reset),
    .alu_wr_valid (alu_wr_valid),
    .alu_wr_addr  (alu_wr_addr),
    .alu_wr_data  (alu_wr_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .rd_addr_0    (rd_addr_0),
    .rd_addr_1    (rd_addr_1),
    .rd_pending_0 (rd_pending_0),
    .rd_pending_1 (rd_pending_1),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .fifo_count   (fifo_count)
  );

  // Reference model: queue of pending loads plus the write-port register.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit model_pending(input logic [4:0] a);
    bit r;
    r = m_en && (m_addr == a);
    foreach (q[i]) if (q[i].live && q[i].addr == a) r = 1'b1;
    return r;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance model, check registers.
  task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] r0, input logic [4:0] r1);
    bit   do_push;
    ent_t e;
    rf_reset = r; alu_wr_valid = av; alu_wr_addr = aa; alu_wr_data = ad;
    mem_wr_valid = mv; mem_wr_addr = ma; mem_wr_data = md;
    rd_addr_0 = r0; rd_addr_1 = r1;
    #1;
    do_push = !r && mv && (q.size() < DEPTH);
    check("mem_wr_ready", 32'(mem_wr_ready), 32'(!r && (q.size() < DEPTH)));
    check("rd_pending_0", 32'(rd_pending_0), 32'(model_pending(r0)));
    check("rd_pending_1", 32'(rd_pending_1), 32'(model_pending(r1)));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      if (av) begin
        foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
        m_en = 1'b1; m_addr = aa; m_data = ad;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_en = e.live;
        if (e.live) begin m_addr = e.addr; m_data = e.data; end
      end else begin
        m_en = 1'b0;
      end
      if (do_push) q.push_back('{ma, md, !(av && aa == ma)});
    end
    @(negedge clk);
    check("rf_wr_enable", 32'(rf_wr_enable), 32'(m_en));
    check("rf_wr_addr",   32'(rf_wr_addr),   32'(m_addr));
    check("rf_wr_data",   rf_wr_data,        m_data);
    check("fifo_count",   32'(fifo_count),   32'(q.size()));
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, r0, r1);
  endtask

  initial begin
    rf_reset = 1'b1; alu_wr_valid = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;
    mem_wr_valid = 1'b0; mem_wr_addr = '0; mem_wr_data = '0; rd_addr_0 = '0; rd_addr_1 = '0;
    m_en = 1'b0; m_addr = '0; m_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_enable", 32'(rf_wr_enable), 32'd0);
    check("reset_addr",   32'(rf_wr_addr),   32'd0);
    check("reset_data",   rf_wr_data,        32'd0);
    check("reset_count",  32'(fifo_count),   32'd0);
    check("reset_ready",  32'(mem_wr_ready), 32'd0);

    // Single ALU write, one-cycle latency.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd6);
    check("alu_data_direct", rf_wr_data, 32'hDEADBEEF);
    idle(5'd5, 5'd6);
    check("alu_enable_drops", 32'(rf_wr_enable), 32'd0);

    // Fill with ALU busy, third offer held off, then drain in order.
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd3, 32'h11, 5'd3, 5'd4);
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd4, 32'h22, 5'd3, 5'd4);
    check("fill_count_direct", 32'(fifo_count), 32'd2);
    cycle(0, 1, 5'd1, 32'h3, 1, 5'd6, 32'h33, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    check("drain_first_direct", rf_wr_data, 32'h11);
    idle(5'd3, 5'd4);
    check("drain_second_direct", rf_wr_data, 32'h22);
    idle(5'd3, 5'd4);

    // Kill rule: buffered load superseded by later ALU write to the same register.
    cycle(0, 1, 5'd1, 32'h5, 1, 5'd7, 32'hAA, 5'd7, 5'd8);
    cycle(0, 1, 5'd7, 32'hBB, 0, 5'd0, 32'd0, 5'd7, 5'd8);
    idle(5'd7, 5'd8);
    check("dead_drain_enable", 32'(rf_wr_enable), 32'd0);
    idle(5'd7, 5'd8);
    // Same-cycle push to the ALU's register is stored dead.
    cycle(0, 1, 5'd9, 32'hC0, 1, 5'd9, 32'hC1, 5'd9, 5'd8);
    idle(5'd9, 5'd8);
    idle(5'd9, 5'd8);

    // Simultaneous push and pop with pointer wrap.
    cycle(0, 1, 5'd1, 32'h7, 1, 5'd9, 32'h99, 5'd9, 5'd10);
    for (int i = 0; i < 10; i++)
      cycle(0, 0, 5'd0, 32'd0, 1, 5'(10 + i), 32'h100 + 32'(i), 5'(10 + i), 5'd9);
    check("pushpop_count_direct", 32'(fifo_count), 32'd1);
    idle(5'd19, 5'd9);
    idle(5'd19, 5'd9);

    // Hazard on a queued live load.
    cycle(0, 1, 5'd1, 32'h8, 1, 5'd12, 32'h1234, 5'd12, 5'd13);
    check("hazard_direct_0", 32'(rd_pending_0), 32'd1);
    check("hazard_direct_1", 32'(rd_pending_1), 32'd0);
    idle(5'd12, 5'd13);
    idle(5'd12, 5'd13);
    check("hazard_clear_direct", 32'(rd_pending_0), 32'd0);

    // Reset mid-operation discards buffered writes.
    cycle(0, 1, 5'd1, 32'h9, 1, 5'd20, 32'h2020, 5'd20, 5'd21);
    cycle(0, 1, 5'd2, 32'hA, 1, 5'd21, 32'h2121, 5'd20, 5'd21);
    cycle(1, 1, 5'd3, 32'hB, 1, 5'd22, 32'h2222, 5'd20, 5'd21);
    check("midreset_count_direct", 32'(fifo_count), 32'd0);
    check("midreset_enable_direct", 32'(rf_wr_enable), 32'd0);
    repeat (3) idle(5'd20, 5'd21);

    // Random traffic over a narrow address range so kills and hazards are frequent.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(63) == 0), ($urandom_range(2) == 0), 5'($urandom_range(7)), $urandom,
            ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom,
            5'($urandom_range(7)), 5'($urandom_range(7)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Drives the single write port (rf_wr_enable/rf_wr_addr/rf_wr_data) of the 2-read/1-write 32x32 register file, sitting on the rf_clock domain.
- Merges two writeback sources:
  - ALU results: highest priority, never stalled.
  - Memory load results: buffered in a small FIFO, back-pressured with a ready signal.
- Reports per-read-port hazards so the decode stage can stall reads of registers whose writes are still in flight.

Parameters:
DEPTH, 2, number of memory-write FIFO entries (legal 1..4)

Ports:
rf_clock  input  1  register-file clock; all state on rising edge
rf_reset  input  1  synchronous active-high reset
alu_wr_valid  input  1  ALU writeback request this cycle
alu_wr_addr  input  5  ALU destination register
alu_wr_data  input  32  ALU result
mem_wr_valid  input  1  memory writeback offered
mem_wr_addr  input  5  memory destination register
mem_wr_data  input  32  load data
mem_wr_ready  output  1  FIFO can accept; push = mem_wr_valid & mem_wr_ready
rd_addr_0  input  5  read port 0 address being issued
rd_addr_1  input  5  read port 1 address being issued
rd_pending_0  output  1  rd_addr_0 has an outstanding write (combinational)
rd_pending_1  output  1  rd_addr_1 has an outstanding write (combinational)
rf_wr_enable  output  1  to register file write enable (registered)
rf_wr_addr  output  5  to register file write address (registered)
rf_wr_data  output  32  to register file write data (registered)
fifo_count  output  3  number of occupied FIFO entries, live or dead

Behaviour:
- Reset (rf_reset high at an edge):
  - FIFO emptied; all entries invalid and live.
  - rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0, fifo_count=0.
  - While rf_reset is high: mem_wr_ready=0 and ALU/memory inputs are ignored.
  - Reset asserted mid-operation discards all buffered writes; no write is emitted on the following cycle.
- Output register (1 cycle latency): each edge it loads exactly one of the following.
  - alu_wr_valid=1: loads the ALU write, rf_wr_enable=1.
  - Otherwise, FIFO non-empty: pops the head.
    - Live head: rf_wr_enable=1 with the head's addr/data.
    - Dead head: popped with rf_wr_enable=0.
  - Otherwise: rf_wr_enable=0; rf_wr_addr and rf_wr_data hold their values.
- mem_wr_ready = !rf_reset & (fifo_count < DEPTH).
  - Depends only on registered count, not on a same-cycle pop.
- FIFO storage:
  - Circular buffer with head/tail pointers wrapping modulo DEPTH.
  - Each entry holds addr, data and a live bit.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Push when full cannot happen because ready=0.
  - Pop when empty is a no-op.
- Ordering rule: an ALU write is always newer than any buffered or concurrently pushed memory write.
  - ALU write accepted with address A: every valid FIFO entry whose addr==A has its live bit cleared that cycle.
  - A memory push in the same cycle with addr==A is stored dead.
  - Dead entries still occupy slots and drain via pop.
  - ALU write and FIFO head pop are never simultaneous, because ALU wins the port.
- Hazard outputs:
  - rd_pending_N = (rf_wr_enable & rf_wr_addr==rd_addr_N) | (any valid live FIFO entry with addr==rd_addr_N).
  - Register 0 is not special-cased.
- fifo_count: range 0..DEPTH, updated each edge as +push -pop.

Test Plan:
- Reset, then alu_wr_valid=1 addr=5 data=0xDEADBEEF for one cycle -> next cycle rf_wr_enable=1, addr=5, data=0xDEADBEEF; following cycle rf_wr_enable=0.
- FIFO fill and drain (DEPTH=2):
  - alu_wr_valid held high; push mem writes (3,0x11) then (4,0x22) -> fifo_count=2 and mem_wr_ready=0 after the second push.
  - Third offer is held off.
  - Drop ALU -> writes addr3/0x11 then addr4/0x22 on consecutive cycles; ready returns to 1 the cycle after the first pop.
- Kill rule:
  - Buffer mem write (7,0xAA) while ALU is busy, then ALU writes (7,0xBB) -> rf port sees only 7/0xBB.
  - The dead entry drains as one cycle with rf_wr_enable=0; rd_pending for addr7 clears once the ALU write leaves the output register.
- Simultaneous push and pop:
  - With count=1, push (9,0x99) in the same cycle the head pops -> count stays 1.
  - Writes are emitted in FIFO order; pointer wrap is exercised over 10 iterations.
- Hazard:
  - FIFO holds live (12,x); rd_addr_0=12, rd_addr_1=13 -> rd_pending_0=1, rd_pending_1=0.
  - After the entry is written and leaves the output register -> rd_pending_0=0.
- Reset mid-operation:
  - With count=2 and rf_wr_enable=1, pulse rf_reset for one cycle -> next cycle count=0, rf_wr_enable=0, mem_wr_ready=0 during reset and 1 after.
  - No stale writes appear afterwards.
